// File: rtl/axi4_pkg.sv
// rtl/axi4_pkg.sv - shared encodings and defaults for the AXI4 memory arbiter
package axi4_pkg;

    localparam int ADDR_W_DEFAULT = 32;
    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_RADDR = 3'd1,
        ARB_RDATA = 3'd2,
        ARB_WADDR = 3'd3,
        ARB_WRESP = 3'd4
    } arb_state_e;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin picker (instruction vs data side)
module rr_arb2
    import axi4_pkg::*;
(
    input  logic req_ifetch,
    input  logic req_data,
    input  logic last_grant,
    output logic any_req,
    output logic pick
);

    always_comb begin
        any_req = req_ifetch | req_data;
        if (req_ifetch && req_data) begin
            pick = ~last_grant;
        end else if (req_data) begin
            pick = GRANT_D;
        end else begin
            pick = GRANT_I;
        end
    end

endmodule

// File: rtl/axi4_mem_arbiter.sv
// rtl/axi4_mem_arbiter.sv - round-robin 2:1 AXI4 arbiter, one outstanding transaction
module axi4_mem_arbiter
    import axi4_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   i_axi_araddr,
    input  logic                i_axi_arvalid,
    output logic                i_axi_arready,
    output logic [DATA_W-1:0]   i_axi_rdata,
    output logic                i_axi_rvalid,
    input  logic                i_axi_rready,
    input  logic [ADDR_W-1:0]   d_axi_araddr,
    input  logic                d_axi_arvalid,
    output logic                d_axi_arready,
    output logic [DATA_W-1:0]   d_axi_rdata,
    output logic                d_axi_rvalid,
    input  logic                d_axi_rready,
    input  logic [ADDR_W-1:0]   d_axi_awaddr,
    input  logic                d_axi_awvalid,
    output logic                d_axi_awready,
    input  logic [DATA_W-1:0]   d_axi_wdata,
    input  logic [DATA_W/8-1:0] d_axi_wstrb,
    input  logic                d_axi_wvalid,
    output logic                d_axi_wready,
    output logic                d_axi_bvalid,
    input  logic                d_axi_bready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready
);

    arb_state_e state, state_next;
    logic       grant, last_grant;
    logic       aw_done, w_done;
    logic       any_req, pick;
    logic       aw_hs, w_hs, write_done;

    rr_arb2 u_rr_arb2 (
        .req_ifetch (i_axi_arvalid),
        .req_data   (d_axi_awvalid | d_axi_arvalid),
        .last_grant (last_grant),
        .any_req    (any_req),
        .pick       (pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            grant      <= GRANT_I;
            last_grant <= GRANT_D;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ARB_IDLE && any_req) begin
                grant      <= pick;
                last_grant <= pick;
            end
            if (state == ARB_WADDR) begin
                if (write_done) begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end else begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next    = state;
        i_axi_arready = 1'b0;
        i_axi_rvalid  = 1'b0;
        d_axi_arready = 1'b0;
        d_axi_rvalid  = 1'b0;
        d_axi_awready = 1'b0;
        d_axi_wready  = 1'b0;
        d_axi_bvalid  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        aw_hs         = 1'b0;
        w_hs          = 1'b0;
        write_done    = 1'b0;
        // Payloads are muxed unconditionally; only the valids are qualified by state.
        i_axi_rdata   = m_axi_rdata;
        d_axi_rdata   = m_axi_rdata;
        m_axi_araddr  = (grant == GRANT_D) ? d_axi_araddr : i_axi_araddr;
        m_axi_awaddr  = d_axi_awaddr;
        m_axi_wdata   = d_axi_wdata;
        m_axi_wstrb   = d_axi_wstrb;

        case (state)
            ARB_IDLE: begin
                if (any_req) begin
                    state_next = (pick == GRANT_D && d_axi_awvalid) ? ARB_WADDR : ARB_RADDR;
                end
            end
            ARB_RADDR: begin
                if (grant == GRANT_D) begin
                    m_axi_arvalid = d_axi_arvalid;
                    d_axi_arready = m_axi_arready;
                end else begin
                    m_axi_arvalid = i_axi_arvalid;
                    i_axi_arready = m_axi_arready;
                end
                if (m_axi_arvalid && m_axi_arready) state_next = ARB_RDATA;
            end
            ARB_RDATA: begin
                if (grant == GRANT_D) begin
                    m_axi_rready = d_axi_rready;
                    d_axi_rvalid = m_axi_rvalid;
                end else begin
                    m_axi_rready = i_axi_rready;
                    i_axi_rvalid = m_axi_rvalid;
                end
                if (m_axi_rvalid && m_axi_rready) state_next = ARB_IDLE;
            end
            ARB_WADDR: begin
                // Each channel is masked once its own beat has been accepted.
                m_axi_awvalid = d_axi_awvalid & ~aw_done;
                d_axi_awready = m_axi_awready & ~aw_done;
                m_axi_wvalid  = d_axi_wvalid & ~w_done;
                d_axi_wready  = m_axi_wready & ~w_done;
                aw_hs         = m_axi_awvalid & m_axi_awready;
                w_hs          = m_axi_wvalid & m_axi_wready;
                write_done    = (aw_done | aw_hs) & (w_done | w_hs);
                if (write_done) state_next = ARB_WRESP;
            end
            ARB_WRESP: begin
                m_axi_bready = d_axi_bready;
                d_axi_bvalid = m_axi_bvalid;
                if (m_axi_bvalid && m_axi_bready) state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi4_mem_arbiter.sv
// tb/tb_axi4_mem_arbiter.sv - directed and randomized checks of axi4_mem_arbiter against a RAM model
module tb_axi4_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [AW-1:0] i_axi_araddr;  logic i_axi_arvalid, i_axi_arready;
    logic [DW-1:0] i_axi_rdata;   logic i_axi_rvalid, i_axi_rready;
    logic [AW-1:0] d_axi_araddr;  logic d_axi_arvalid, d_axi_arready;
    logic [DW-1:0] d_axi_rdata;   logic d_axi_rvalid, d_axi_rready;
    logic [AW-1:0] d_axi_awaddr;  logic d_axi_awvalid, d_axi_awready;
    logic [DW-1:0] d_axi_wdata;   logic [SW-1:0] d_axi_wstrb;
    logic d_axi_wvalid, d_axi_wready, d_axi_bvalid, d_axi_bready;
    logic [AW-1:0] m_axi_araddr;  logic m_axi_arvalid, m_axi_arready;
    logic [DW-1:0] m_axi_rdata;   logic m_axi_rvalid, m_axi_rready;
    logic [AW-1:0] m_axi_awaddr;  logic m_axi_awvalid, m_axi_awready;
    logic [DW-1:0] m_axi_wdata;   logic [SW-1:0] m_axi_wstrb;
    logic m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;

    axi4_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .i_axi_araddr(i_axi_araddr), .i_axi_arvalid(i_axi_arvalid), .i_axi_arready(i_axi_arready),
        .i_axi_rdata(i_axi_rdata), .i_axi_rvalid(i_axi_rvalid), .i_axi_rready(i_axi_rready),
        .d_axi_araddr(d_axi_araddr), .d_axi_arvalid(d_axi_arvalid), .d_axi_arready(d_axi_arready),
        .d_axi_rdata(d_axi_rdata), .d_axi_rvalid(d_axi_rvalid), .d_axi_rready(d_axi_rready),
        .d_axi_awaddr(d_axi_awaddr), .d_axi_awvalid(d_axi_awvalid), .d_axi_awready(d_axi_awready),
        .d_axi_wdata(d_axi_wdata), .d_axi_wstrb(d_axi_wstrb), .d_axi_wvalid(d_axi_wvalid),
        .d_axi_wready(d_axi_wready), .d_axi_bvalid(d_axi_bvalid), .d_axi_bready(d_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    // RAM slave: word array, configurable read latency and AW/W accept delays
    logic [DW-1:0] ram [0:255];
    logic          r_busy, aw_got, w_got;
    int            r_cnt, aw_wait, w_wait;
    logic [7:0]    r_idx, w_idx;
    logic [DW-1:0] w_data;
    logic [SW-1:0] w_strb;
    int s_lat = 2, s_aw_dly = 0, s_w_dly = 0;
    int s_viol = 0, s_writes = 0;

    assign m_axi_arready = !r_busy;
    assign m_axi_awready = !aw_got && (aw_wait >= s_aw_dly);
    assign m_axi_wready  = !w_got && (w_wait >= s_w_dly);

    function automatic logic [DW-1:0] init_word(int k);
        logic [DW-1:0] v;
        v = 32'h9E37_79B9 * 32'(k + 1);
        return (k == 8'h80) ? '0 : v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 256; k++) ram[k] <= init_word(k);
            r_busy <= 1'b0; r_cnt <= 0; r_idx <= '0;
            m_axi_rvalid <= 1'b0; m_axi_rdata <= '0; m_axi_bvalid <= 1'b0;
            aw_got <= 1'b0; w_got <= 1'b0; aw_wait <= 0; w_wait <= 0;
            w_idx <= '0; w_data <= '0; w_strb <= '0;
        end else begin
            s_viol <= s_viol + int'(m_axi_arvalid && r_busy) + int'(m_axi_awvalid && aw_got)
                              + int'(m_axi_wvalid && w_got);
            if (m_axi_arvalid && m_axi_arready) begin
                r_busy <= 1'b1; r_cnt <= s_lat; r_idx <= m_axi_araddr[9:2];
            end else if (r_busy && !m_axi_rvalid) begin
                if (r_cnt > 0) r_cnt <= r_cnt - 1;
                else begin m_axi_rvalid <= 1'b1; m_axi_rdata <= ram[r_idx]; end
            end
            if (m_axi_rvalid && m_axi_rready) begin m_axi_rvalid <= 1'b0; r_busy <= 1'b0; end
            if (m_axi_awvalid && !aw_got) aw_wait <= aw_wait + 1;
            if (m_axi_awvalid && m_axi_awready) begin aw_got <= 1'b1; w_idx <= m_axi_awaddr[9:2]; aw_wait <= 0; end
            if (m_axi_wvalid && !w_got) w_wait <= w_wait + 1;
            if (m_axi_wvalid && m_axi_wready) begin w_got <= 1'b1; w_data <= m_axi_wdata; w_strb <= m_axi_wstrb; w_wait <= 0; end
            if (aw_got && w_got && !m_axi_bvalid) begin
                for (int b = 0; b < SW; b++) if (w_strb[b]) ram[w_idx][8*b +: 8] <= w_data[8*b +: 8];
                s_writes <= s_writes + 1;
                m_axi_bvalid <= 1'b1;
            end
            if (m_axi_bvalid && m_axi_bready) begin m_axi_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; end
        end
    end

    int checks = 0, errors = 0;
    int outstanding = 0, cyc = 0, mv_cyc = -1, issue_cyc = 0;
    int b_pulses = 0, cross_viol = 0;
    int d_aw_cnt = 0, d_w_cnt = 0;
    bit d_aw_pend = 0, d_w_pend = 0, d_seen = 0, rand_rdy = 0;
    int act_port[$], exp_port[$];
    logic [DW-1:0] act_data[$], exp_data[$];
    logic [DW-1:0] ref_mem [0:255];
    bit model_last_d;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ctrl_outs();
        return {i_axi_arready, i_axi_rvalid, d_axi_arready, d_axi_rvalid, d_axi_awready, d_axi_wready,
                d_axi_bvalid, m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
        model_last_d = 1'b1;
    endtask

    // One granted transaction in the reference: port 0 = I read, 1 = D read, 2 = D write
    task automatic model_serve(int port, logic [AW-1:0] addr, logic [DW-1:0] wd, logic [SW-1:0] ws);
        int idx;
        idx = int'(addr[9:2]);
        exp_port.push_back(port);
        if (port == 2) begin
            for (int b = 0; b < SW; b++) if (ws[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
            exp_data.push_back('0);
        end else begin
            exp_data.push_back(ref_mem[idx]);
        end
        model_last_d = (port != 0);
    endtask

    task automatic step();
        bit i_ar, i_r, d_ar, d_r, d_aw, d_w, d_b;
        @(negedge clk);
        i_ar = i_axi_arvalid && i_axi_arready;
        i_r  = i_axi_rvalid && i_axi_rready;
        d_ar = d_axi_arvalid && d_axi_arready;
        d_r  = d_axi_rvalid && d_axi_rready;
        d_aw = d_axi_awvalid && d_axi_awready;
        d_w  = d_axi_wvalid && d_axi_wready;
        d_b  = d_axi_bvalid && d_axi_bready;
        if ((i_axi_arready || i_axi_rvalid) &&
            (d_axi_arready || d_axi_rvalid || d_axi_awready || d_axi_wready || d_axi_bvalid)) cross_viol++;
        if (d_axi_arready || d_axi_rvalid || d_axi_awready || d_axi_wready || d_axi_bvalid) d_seen = 1;
        if (mv_cyc < 0 && (m_axi_arvalid || m_axi_awvalid)) mv_cyc = cyc;
        if (i_r) begin act_port.push_back(0); act_data.push_back(i_axi_rdata); outstanding--; end
        if (d_r) begin act_port.push_back(1); act_data.push_back(d_axi_rdata); outstanding--; end
        if (d_b) begin act_port.push_back(2); act_data.push_back('0); outstanding--; b_pulses++; end
        @(posedge clk);
        #1;
        cyc++;
        if (i_ar) i_axi_arvalid = 1'b0;
        if (d_ar) d_axi_arvalid = 1'b0;
        if (d_aw) d_axi_awvalid = 1'b0;
        if (d_w)  d_axi_wvalid  = 1'b0;
        if (d_aw_pend) begin
            if (d_aw_cnt == 0) begin d_axi_awvalid = 1'b1; d_aw_pend = 0; end else d_aw_cnt--;
        end
        if (d_w_pend) begin
            if (d_w_cnt == 0) begin d_axi_wvalid = 1'b1; d_w_pend = 0; end else d_w_cnt--;
        end
        i_axi_rready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
        d_axi_rready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
        d_axi_bready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
    endtask

    // Issue an I read and/or one D op together, predict service order, then compare completions
    task automatic run_txn(string tag, bit do_i, logic [AW-1:0] ia, int d_op, logic [AW-1:0] da,
                           logic [DW-1:0] wd, logic [SW-1:0] ws, int aw_dly, int w_dly);
        int n;
        bit d_first;
        act_port.delete(); act_data.delete(); exp_port.delete(); exp_data.delete();
        d_first = (do_i && d_op != 0) ? !model_last_d : (d_op != 0);
        if (d_first) model_serve(d_op, da, wd, ws);
        if (do_i) model_serve(0, ia, '0, '0);
        if (!d_first && d_op != 0) model_serve(d_op, da, wd, ws);
        mv_cyc = -1; issue_cyc = cyc; d_seen = 0;
        if (do_i) begin i_axi_araddr = ia; i_axi_arvalid = 1'b1; outstanding++; end
        if (d_op == 1) begin d_axi_araddr = da; d_axi_arvalid = 1'b1; outstanding++; end
        if (d_op == 2) begin
            d_axi_awaddr = da; d_axi_wdata = wd; d_axi_wstrb = ws; outstanding++;
            if (aw_dly == 0) d_axi_awvalid = 1'b1; else begin d_aw_pend = 1; d_aw_cnt = aw_dly - 1; end
            if (w_dly == 0) d_axi_wvalid = 1'b1; else begin d_w_pend = 1; d_w_cnt = w_dly - 1; end
        end
        n = 0;
        while (outstanding > 0 && n < 400) begin step(); n++; end
        chk({tag, " pending"}, 64'(outstanding), 64'd0);
        chk({tag, " count"}, 64'(act_port.size()), 64'(exp_port.size()));
        for (int k = 0; k < exp_port.size() && k < act_port.size(); k++) begin
            chk($sformatf("%s port%0d", tag, k), 64'(act_port[k]), 64'(exp_port[k]));
            chk($sformatf("%s data%0d", tag, k), 64'(act_data[k]), 64'(exp_data[k]));
        end
    endtask

    task automatic apply_reset(int n);
        rst = 1'b1;
        i_axi_arvalid = 0; d_axi_arvalid = 0; d_axi_awvalid = 0; d_axi_wvalid = 0;
        d_aw_pend = 0; d_w_pend = 0; outstanding = 0;
        repeat (n) @(posedge clk);
        #1;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0, b0, v0;
        logic [AW-1:0] a1, a2;
        logic [DW-1:0] wd;
        int kind, d_op;
        rst = 1'b1;
        i_axi_araddr = '0; i_axi_arvalid = 0; i_axi_rready = 1;
        d_axi_araddr = '0; d_axi_arvalid = 0; d_axi_rready = 1;
        d_axi_awaddr = '0; d_axi_awvalid = 0; d_axi_wdata = '0; d_axi_wstrb = '0;
        d_axi_wvalid = 0; d_axi_bready = 1;

        apply_reset(3);
        chk("reset outputs", 64'(ctrl_outs()), 64'd0);
        rst = 1'b0;

        s_lat = 20;
        v0 = s_viol;
        run_txn("single_i", 1, 32'h100, 0, '0, '0, '0, 0, 0);
        chk("single_i data", 64'(act_data.size() > 0 ? act_data[0] : '0), 64'(init_word(32'h40)));
        chk("single_i d quiet", 64'(d_seen), 64'd0);
        chk("single_i arb latency", 64'(mv_cyc - issue_cyc), 64'd1);

        apply_reset(1); rst = 1'b0;
        s_lat = 1;
        for (int t = 0; t < 4; t++) begin
            a1 = 32'($urandom_range(0, 255)) << 2;
            a2 = 32'($urandom_range(0, 255)) << 2;
            run_txn($sformatf("tie%0d", t), 1, a1, 1, a2, '0, '0, 0, 0);
            chk($sformatf("tie%0d winner", t), 64'(act_port.size() > 0 ? act_port[0] : -1), 64'd0);
        end

        wr0 = s_writes; b0 = b_pulses;
        run_txn("strobe_wr", 0, '0, 2, 32'h200, 32'hDEAD_BEEF, 4'b0011, 0, 0);
        chk("strobe_wr writes", 64'(s_writes - wr0), 64'd1);
        chk("strobe_wr bvalid pulses", 64'(b_pulses - b0), 64'd1);
        run_txn("strobe_rd", 0, '0, 1, 32'h200, '0, '0, 0, 0);
        chk("strobe_rd value", 64'(act_data.size() > 0 ? act_data[0] : '0), 64'h0000_BEEF);

        s_aw_dly = 3;
        wr0 = s_writes; b0 = b_pulses;
        run_txn("w_first", 0, '0, 2, 32'h3F0, 32'h1234_5678, 4'b1111, 3, 0);
        chk("w_first writes", 64'(s_writes - wr0), 64'd1);
        chk("w_first bvalid pulses", 64'(b_pulses - b0), 64'd1);
        s_aw_dly = 0;
        run_txn("w_first rd", 1, 32'h3F0, 0, '0, '0, '0, 0, 0);
        chk("slave protocol", 64'(s_viol - v0), 64'd0);

        s_lat = 20;
        i_axi_araddr = 32'h40; i_axi_arvalid = 1'b1; outstanding = 1;
        for (int n = 0; n < 20 && i_axi_arvalid; n++) step();
        repeat (3) step();
        rst = 1'b1; i_axi_arvalid = 1'b0; outstanding = 0;
        @(posedge clk);
        #1;
        chk("mid reset outputs", 64'(ctrl_outs()), 64'd0);
        rst = 1'b0;
        model_reset();
        s_lat = 2;
        run_txn("after_reset", 1, 32'h84, 0, '0, '0, '0, 0, 0);

        rand_rdy = 1;
        v0 = s_viol; cross_viol = 0;
        for (int t = 0; t < 40; t++) begin
            s_lat = $urandom_range(0, 6);
            s_aw_dly = $urandom_range(0, 3);
            s_w_dly = $urandom_range(0, 3);
            kind = $urandom_range(0, 3);
            d_op = (kind == 1) ? 1 : (kind == 2) ? 2 : (kind == 3) ? $urandom_range(1, 2) : 0;
            a1 = 32'($urandom_range(0, 255)) << 2;
            a2 = 32'($urandom_range(0, 15)) << 2;
            wd = $urandom;
            run_txn($sformatf("rnd%0d", t), (kind == 0 || kind == 3), a2, d_op, a1 ^ a2, wd,
                    4'($urandom_range(1, 15)), 0, $urandom_range(0, 2));
        end
        chk("rnd slave protocol", 64'(s_viol - v0), 64'd0);
        chk("rnd ungranted quiet", 64'(cross_viol), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_mem_arbiter.md
# axi4_mem_arbiter

Two-to-one AXI4 arbiter that shares the single AXI4 RAM slave between the instruction-fetch port (read-only) and the data-memory port (read/write) of the pipelined RV32 core. It allows one outstanding transaction at a time. Arbitration between the two requesters is round-robin, and the grant is held until the response handshake completes. It sits between the core's I/D bus masters and the RAM model or memory controller.

## Interface
Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- i_axi_araddr / i_axi_arvalid / i_axi_arready  in/in/out  ADDR_W/1/1  instruction read address channel.
- i_axi_rdata / i_axi_rvalid / i_axi_rready  out/out/in  DATA_W/1/1  instruction read data channel.
- d_axi_araddr / d_axi_arvalid / d_axi_arready  in/in/out  ADDR_W/1/1  data read address channel.
- d_axi_rdata / d_axi_rvalid / d_axi_rready  out/out/in  DATA_W/1/1  data read data channel.
- d_axi_awaddr / d_axi_awvalid / d_axi_awready  in/in/out  ADDR_W/1/1  data write address channel.
- d_axi_wdata / d_axi_wstrb / d_axi_wvalid / d_axi_wready  in/in/in/out  DATA_W/DATA_W/8/1/1  data write data channel.
- d_axi_bvalid / d_axi_bready  out/in  1/1  data write response channel.
- m_axi_ar*, m_axi_r*, m_axi_aw*, m_axi_w*, m_axi_b*  (same channel set, directions mirrored)  downstream master port to the RAM slave.

## Operation
- FSM states: IDLE, RADDR, RDATA, WADDR, WRESP.
- IDLE:
  - Sample requests: I = i_axi_arvalid; D = d_axi_awvalid | d_axi_arvalid.
  - If both I and D request, grant the side not granted last. last_grant resets to D, so I wins the first tie.
  - On a D grant, d write (awvalid) wins over d read.
  - Register grant and last_grant, then go to RADDR (read) or WADDR (write).
- RADDR: forward the granted araddr/arvalid to m_axi; route m_axi_arready back to the granted master only. On m_axi_arvalid & m_axi_arready, go to RDATA.
- RDATA: route m_axi_rdata/rvalid to the granted master; m_axi_rready = granted rready. On rvalid & rready, go to IDLE.
- WADDR:
  - Forward AW and W concurrently. AW is masked once the aw_done flag is set; W is masked once w_done is set.
  - Each flag is set on its own handshake.
  - When both flags are set (either may complete first, or both in the same cycle), clear the flags and go to WRESP.
- WRESP: route bvalid/bready. On handshake, go to IDLE.
- Ungranted master: arready, rvalid, awready, wready and bvalid are held 0. Its requests stay pending; masters are required to hold valid per AXI.
- Downstream valids are 0 in IDLE. rdata/addr/wdata/wstrb are muxed from the grant and are don't-care while the corresponding valid is low.
- No reordering, no response codes (no rresp/bresp), no bursts.

## Timing
- Reset (rst=1 at posedge): state=IDLE, last_grant=D, aw_done=w_done=0. All valid/ready outputs are 0 on every port.
- rst mid-transaction aborts to IDLE with no response delivered. The RAM slave must be reset in the same cycle.
- Arbitration latency is 1 cycle: a request seen in IDLE at edge N drives m_axi_*valid from cycle N+1.
- Ready/valid forwarding in RADDR/RDATA/WADDR/WRESP is combinational; the block adds zero extra cycles per beat.
- Minimum read occupancy is 1 (IDLE) + address handshake + slave latency + 1 data beat. The next arbitration happens in the cycle after the R handshake.
- A new request arriving while busy waits until the next IDLE. A request arriving in the same cycle as the response handshake is considered in that following IDLE cycle.

## Structure
- Shared package `axi4_pkg`:
  - Localparam state encodings (ARB_IDLE..ARB_WRESP).
  - GRANT_I/GRANT_D constants.
  - Default ADDR_W/DATA_W.
- A single flat module; the channel muxes are inline.
- Natural optional sub-module: `rr_arb2`, the combinational 2-way round-robin picker with last_grant input.

## Test plan
- Reset and idle: assert rst for 3 cycles, no requests. All m_axi/i/d valid and ready outputs read 0 and state=IDLE.
- Single I read: i_axi_araddr=0x100, RAM LATENCY=20. i_axi_rdata = mem[0x40] after one handshake, and d-side outputs stay 0 throughout.
- Tie round-robin: I and D reads asserted in the same cycle, repeated 4 times. Grant order is I, D, I, D.
- D write, strobed: d_axi_awaddr=0x200, wdata=0xDEADBEEF, wstrb=4'b0011. A later read of 0x200 returns 0x0000BEEF over a zeroed word, and exactly one bvalid pulse reaches d.
- W before AW: drive d_axi_wvalid 3 cycles before awvalid. The FSM stays in WADDR until both flags are set, then exactly one write lands.
- Reset mid-read: assert rst during RDATA before rvalid. Next cycle all outputs are 0, and a subsequent I read completes normally.
